mem_port_arbiter: RTL and testbench

- Shares one single-port, 128-bit-line data/instruction memory between the instruction fetch unit and the load/store unit.
- Sequences each access: arbitration, issue, fixed-latency wait, response.
- Performs byte-lane placement of store data and the active-low byte write mask. Performs lane extraction of read data.
- Sits between the core (fetch + load/store controller outputs addr_out/w_out/wr/wr_mask) and the memory macro.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_lane_aligner.sv | 29 ++
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory port arbiter:
// FSM state encoding, memory line geometry and requester identifiers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int LINE_BYTES = 16;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_lane_aligner.sv
// Byte-lane aligner between a 32-bit core word and a 128-bit memory line.
// Places store data and the active-low byte mask at the line offset, flags
// accesses whose enabled bytes spill past the end of the line, and extracts
// the 32 bits starting at the offset from a read line.
module mem_port_arbiter_lane_aligner
    import mem_port_arbiter_pkg::*;
(
    input  logic [3:0]              offset,
    input  logic [31:0]             word_in,
    input  logic [3:0]              mask_in,
    input  logic [8*LINE_BYTES-1:0] line_in,
    output logic [8*LINE_BYTES-1:0] line_out,
    output logic [LINE_BYTES-1:0]   mask_out,
    output logic [31:0]             word_out,
    output logic                    cross_err
);

    logic [2*LINE_BYTES-1:0] byte_en;

    // Shift the byte enables over a double-width window so that any enable landing past byte 15 marks a line crossing
    always_comb begin
        byte_en   = {28'd0, ~mask_in} << offset;
        mask_out  = ~byte_en[LINE_BYTES-1:0];
        cross_err = |byte_en[2*LINE_BYTES-1:LINE_BYTES];
        line_out  = {96'd0, word_in} << {offset, 3'b000};
        word_out  = 32'(line_in >> {offset, 3'b000});
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port 128-bit-line memory between the
// instruction fetch unit and the load/store unit. One access is in flight at
// a time: IDLE (arbitrate/grant) -> ISSUE (strobe memory) -> WAIT (fixed read
// latency) -> RESP (one-cycle response pulse).
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// conflicting requests; otherwise the load/store unit always wins.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    input  logic [15:0]       ls_wmask,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-5:0] mem_addr,
    output logic [127:0]      mem_wdata,
    output logic [15:0]       mem_wmask,
    input  logic [127:0]      mem_rdata
);

    state_t            state;
    state_t            next_state;
    logic              any_req;
    logic              winner;
    logic              owner;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_mask;
    logic              cap_we;
    logic              err_q;
    logic [2:0]        wait_cnt;
    logic [31:0]       if_rdata_q;
    logic [31:0]       ls_rdata_q;
    logic [127:0]      line_data;
    logic [15:0]       line_mask;
    logic [31:0]       read_word;
    logic              cross_err;
    logic              acc_err;
    logic              unused_mask_bits;

    // Only the low four mask bits describe a 32-bit access
    assign unused_mask_bits = ^ls_wmask[15:4];
    assign any_req          = if_req | ls_req;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;

    // On conflict the pointer picks the winner; a lone requester always wins
    always_comb begin
        if (if_req && ls_req) winner = rr_ptr;
        else                  winner = ls_req ? REQ_LS : REQ_IF;
    end

    // After every grant the pointer moves to the requester that did not win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      rr_ptr <= REQ_IF;
        else if (state == IDLE && any_req) rr_ptr <= ~winner;
    end
`else
    // Fixed priority: the load/store unit wins every conflict
    always_comb begin
        winner = ls_req ? REQ_LS : REQ_IF;
    end
`endif

    mem_port_arbiter_lane_aligner u_lane_aligner (
        .offset    (cap_addr[3:0]),
        .word_in   (cap_wdata),
        .mask_in   (cap_mask),
        .line_in   (mem_rdata),
        .line_out  (line_data),
        .mask_out  (line_mask),
        .word_out  (read_word),
        .cross_err (cross_err)
    );

    // Fetches must be word aligned; any access spilling past the line is rejected
    assign acc_err  = cross_err | ((owner == REQ_IF) && (cap_addr[1:0] != 2'b00));
    assign mem_addr = cap_addr[ADDR_W-1:4];
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode and all strobe outputs; grants are suppressed while reset is held
    always_comb begin
        next_state = state;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        ls_rvalid  = 1'b0;
        if_err     = 1'b0;
        ls_err     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        mem_wmask  = '1;
        case (state)
            IDLE: begin
                if (any_req && rst_n) begin
                    next_state = ISSUE;
                    if (winner == REQ_LS) ls_gnt = 1'b1;
                    else                  if_gnt = 1'b1;
                end
            end
            ISSUE: begin
                if (acc_err) begin
                    next_state = RESP;
                end else begin
                    mem_en = 1'b1;
                    if (cap_we) begin
                        mem_we     = 1'b1;
                        mem_wdata  = line_data;
                        mem_wmask  = line_mask;
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) next_state = RESP;
            end
            RESP: begin
                next_state = IDLE;
                if (owner == REQ_LS) begin
                    ls_rvalid = 1'b1;
                    ls_err    = err_q;
                end else begin
                    if_rvalid = 1'b1;
                    if_err    = err_q;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the granted request, count the read latency and hold each requester's last read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= REQ_IF;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_mask   <= '1;
            cap_we     <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt   <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        if (winner == REQ_LS) begin
                            cap_addr  <= ls_addr;
                            cap_wdata <= ls_wdata;
                            cap_mask  <= ls_wmask[3:0];
                            cap_we    <= ls_we;
                        end else begin
                            cap_addr  <= if_addr;
                            cap_wdata <= '0;
                            cap_mask  <= 4'b0000;
                            cap_we    <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    err_q    <= acc_err;
                    wait_cnt <= 3'(MEM_LAT - 1);
                    if (acc_err) begin
                        if (owner == REQ_LS) ls_rdata_q <= '0;
                        else                 if_rdata_q <= '0;
                    end
                end
                WAIT: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (owner == REQ_LS) begin
                        ls_rdata_q <= read_word;
                    end else begin
                        if_rdata_q <= read_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. The main instance uses
// MEM_LAT=2; two extra instances with MEM_LAT=1 and MEM_LAT=7 check the
// latency extremes on a fetch. Expected grant order follows MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         if_req = 1'b0;
    logic [31:0]  if_addr = '0;
    logic         ls_req = 1'b0;
    logic         ls_we = 1'b0;
    logic [31:0]  ls_addr = '0;
    logic [31:0]  ls_wdata = '0;
    logic [15:0]  ls_wmask = 16'hFFFF;
    logic [127:0] mem_rdata = 128'h8011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    logic         if_req_aux = 1'b0;

    logic         if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
    logic [31:0]  if_rdata, ls_rdata;
    logic         mem_en, mem_we;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_wmask;

    logic         a1_if_gnt, a1_if_rvalid;
    logic [31:0]  a1_if_rdata;
    logic         a1_unused_if_err, a1_unused_ls_gnt, a1_unused_ls_rvalid, a1_unused_ls_err;
    logic [31:0]  a1_unused_ls_rdata;
    logic         a1_unused_mem_en, a1_unused_mem_we;
    logic [27:0]  a1_unused_mem_addr;
    logic [127:0] a1_unused_mem_wdata;
    logic [15:0]  a1_unused_mem_wmask;

    logic         a7_if_gnt, a7_if_rvalid;
    logic [31:0]  a7_if_rdata;
    logic         a7_unused_if_err, a7_unused_ls_gnt, a7_unused_ls_rvalid, a7_unused_ls_err;
    logic [31:0]  a7_unused_ls_rdata;
    logic         a7_unused_mem_en, a7_unused_mem_we;
    logic [27:0]  a7_unused_mem_addr;
    logic [127:0] a7_unused_mem_wdata;
    logic [15:0]  a7_unused_mem_wmask;

    int           compared = 0;
    int           mismatched = 0;
    int           cyc = 0;
    int           en_count = 0;
    logic [27:0]  mon_addr = '0;
    logic         mon_we = 1'b0;
    logic [15:0]  mon_wmask = '0;
    logic [127:0] mon_wdata = '0;
    logic         last_err = 1'b0;
    logic [31:0]  last_rdata = '0;

    mem_port_arbiter #(.MEM_LAT(2), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ls_err(ls_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(32)) dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_aux), .if_addr(if_addr), .if_gnt(a1_if_gnt), .if_rvalid(a1_if_rvalid),
        .if_rdata(a1_if_rdata), .if_err(a1_unused_if_err),
        .ls_req(1'b0), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_gnt(a1_unused_ls_gnt), .ls_rvalid(a1_unused_ls_rvalid),
        .ls_rdata(a1_unused_ls_rdata), .ls_err(a1_unused_ls_err),
        .mem_en(a1_unused_mem_en), .mem_we(a1_unused_mem_we), .mem_addr(a1_unused_mem_addr),
        .mem_wdata(a1_unused_mem_wdata), .mem_wmask(a1_unused_mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(7), .ADDR_W(32)) dut_lat7 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_aux), .if_addr(if_addr), .if_gnt(a7_if_gnt), .if_rvalid(a7_if_rvalid),
        .if_rdata(a7_if_rdata), .if_err(a7_unused_if_err),
        .ls_req(1'b0), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_gnt(a7_unused_ls_gnt), .ls_rvalid(a7_unused_ls_rvalid),
        .ls_rdata(a7_unused_ls_rdata), .ls_err(a7_unused_ls_err),
        .mem_en(a7_unused_mem_en), .mem_we(a7_unused_mem_we), .mem_addr(a7_unused_mem_addr),
        .mem_wdata(a7_unused_mem_wdata), .mem_wmask(a7_unused_mem_wmask), .mem_rdata(mem_rdata)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to measure grant-to-response latency
    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory strobe of the main instance
    always @(negedge clk) begin
        if (mem_en) begin
            en_count  = en_count + 1;
            mon_addr  = mem_addr;
            mon_we    = mem_we;
            mon_wmask = mem_wmask;
            mon_wdata = mem_wdata;
        end
    end

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One request on the main instance; returns gnt->rvalid cycles or -1 on timeout
    task automatic apply_stimulus(input logic is_ls, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [15:0] wmask,
                                  output int lat);
        int g;
        int r;
        g = -1;
        r = -1;
        @(posedge clk); #1;
        if (is_ls) begin
            ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_wmask = wmask; ls_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        for (int c = 0; c < 20 && g < 0; c++) begin
            @(negedge clk);
            if (is_ls ? ls_gnt : if_gnt) g = cyc;
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
        if_req = 1'b0;
        for (int c = 0; c < 30 && r < 0; c++) begin
            @(negedge clk);
            if (is_ls ? ls_rvalid : if_rvalid) begin
                r          = cyc;
                last_err   = is_ls ? ls_err : if_err;
                last_rdata = is_ls ? ls_rdata : if_rdata;
            end
        end
        lat = (g < 0 || r < 0) ? -1 : r - g;
    endtask

    function automatic logic [1:0] exp_grant(input int n);
`ifdef MEM_ARB_RR_EN
        return (n % 2 == 0) ? 2'b10 : 2'b01;
`else
        return 2'b01;
`endif
    endfunction

    // Directed test sequence
    initial begin
        int lat;
        int base;
        int n;
        int rv;
        int g1, g7, r1, r7;
        logic [31:0] d1, d7;

        // Reset values, with a request held to show grants stay low
        ls_req = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rst_ls_gnt", ls_gnt, 1'b0);
        check_output("rst_if_gnt", if_gnt, 1'b0);
        check_output("rst_mem_en", mem_en, 1'b0);
        check_output("rst_mem_we", mem_we, 1'b0);
        check_output("rst_mem_wmask", mem_wmask, 16'hFFFF);
        check_output("rst_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
        check_output("rst_mem_addr", mem_addr, 28'h0);
        ls_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Both requesters held for six grants
        @(posedge clk); #1;
        ls_we = 1'b0; ls_addr = 32'h100; ls_wmask = 16'hFFF0; if_addr = 32'h200;
        if_req = 1'b1; ls_req = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) begin
                check_output($sformatf("arb_grant%0d", n), {if_gnt, ls_gnt}, exp_grant(n));
                n++;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;
        check_output("arb_grant_count", n, 6);
        rv = 0;
        for (int c = 0; c < 30 && rv == 0; c++) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) rv = 1;
        end
        check_output("arb_drain", rv, 1);

        // Store word at 0x104: bytes 4..7 written, so mask bits 7:4 low
        base = en_count;
        apply_stimulus(1'b1, 1'b1, 32'h104, 32'hDEADBEEF, 16'hFFF0, lat);
        check_output("st_lat", lat, 2);
        check_output("st_err", last_err, 1'b0);
        check_output("st_en_count", en_count - base, 1);
        check_output("st_addr", mon_addr, 28'h10);
        check_output("st_we", mon_we, 1'b1);
        check_output("st_wmask", mon_wmask, 16'hFF0F);
        check_output("st_wdata", mon_wdata, 128'h0000_0000_0000_0000_DEADBEEF_0000_0000);

        // Load byte at the last byte of the line
        base = en_count;
        apply_stimulus(1'b1, 1'b0, 32'h10F, 32'h0, 16'hFFFE, lat);
        check_output("ld_lat", lat, 4);
        check_output("ld_err", last_err, 1'b0);
        check_output("ld_rdata", last_rdata, 32'h0000_0080);
        check_output("ld_en_count", en_count - base, 1);
        check_output("ld_we", mon_we, 1'b0);
        check_output("ld_wmask", mon_wmask, 16'hFFFF);
        check_output("ld_addr", mon_addr, 28'h10);

        // Reset asserted while a load waits on memory
        @(posedge clk); #1;
        ls_we = 1'b0; ls_addr = 32'h10F; ls_wmask = 16'hFFFE; ls_req = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n == 0; c++) begin
            @(negedge clk);
            if (ls_gnt) n = 1;
        end
        check_output("rw_gnt", n, 1);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_output("rw_ls_rdata", ls_rdata, 32'h0);
        check_output("rw_if_rdata", if_rdata, 32'h0);
        check_output("rw_mem_wmask", mem_wmask, 16'hFFFF);
        check_output("rw_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rv = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) rv++;
        end
        check_output("rw_no_resp", rv, 0);
        apply_stimulus(1'b1, 1'b0, 32'h10F, 32'h0, 16'hFFFE, lat);
        check_output("rw_after_lat", lat, 4);
        check_output("rw_after_rdata", last_rdata, 32'h0000_0080);

        // Store half crossing the line end
        base = en_count;
        apply_stimulus(1'b1, 1'b1, 32'h10F, 32'h0000_1234, 16'hFFFC, lat);
        check_output("sx_lat", lat, 2);
        check_output("sx_err", last_err, 1'b1);
        check_output("sx_rdata", last_rdata, 32'h0);
        check_output("sx_no_mem_en", en_count - base, 0);

        // Misaligned fetch
        base = en_count;
        apply_stimulus(1'b0, 1'b0, 32'h102, 32'h0, 16'hFFFF, lat);
        check_output("fx_lat", lat, 2);
        check_output("fx_err", last_err, 1'b1);
        check_output("fx_no_mem_en", en_count - base, 0);

        // Aligned fetch at 0x208 on the main instance
        apply_stimulus(1'b0, 1'b0, 32'h208, 32'h0, 16'hFFFF, lat);
        check_output("f2_lat", lat, 4);
        check_output("f2_err", last_err, 1'b0);
        check_output("f2_rdata", last_rdata, 32'h4455_6677);

        // Same fetch on the MEM_LAT=1 and MEM_LAT=7 instances
        g1 = -1; g7 = -1; r1 = -1; r7 = -1; d1 = '0; d7 = '0;
        @(posedge clk); #1;
        if_addr = 32'h208;
        if_req_aux = 1'b1;
        for (int c = 0; c < 20 && (g1 < 0 || g7 < 0); c++) begin
            @(negedge clk);
            if (a1_if_gnt && g1 < 0) g1 = cyc;
            if (a7_if_gnt && g7 < 0) g7 = cyc;
        end
        @(posedge clk); #1;
        if_req_aux = 1'b0;
        for (int c = 0; c < 30 && (r1 < 0 || r7 < 0); c++) begin
            @(negedge clk);
            if (a1_if_rvalid && r1 < 0) begin r1 = cyc; d1 = a1_if_rdata; end
            if (a7_if_rvalid && r7 < 0) begin r7 = cyc; d7 = a7_if_rdata; end
        end
        check_output("lat1_cycles", (g1 < 0 || r1 < 0) ? -1 : r1 - g1, 3);
        check_output("lat7_cycles", (g7 < 0 || r7 < 0) ? -1 : r7 - g7, 9);
        check_output("lat1_rdata", d1, 32'h4455_6677);
        check_output("lat7_rdata", d7, 32'h4455_6677);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
